// File: rtl/shift_word_serializer.sv
// rtl/shift_word_serializer.sv - parallel-in, serial-out word serializer with valid/ready handshakes
module shift_word_serializer #(
  parameter int SIZE      = 512,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(SIZE) + 1
) (
  input  logic             shift_word_serializer_port_clk,
  input  logic             shift_word_serializer_port_rst,
  input  logic             shift_word_serializer_port_en,
  input  logic             shift_word_serializer_port_in_valid,
  output logic             shift_word_serializer_port_in_ready,
  input  logic [SIZE-1:0]  shift_word_serializer_port_in_data,
  input  logic             shift_word_serializer_port_out_ready,
  output logic             shift_word_serializer_port_out_valid,
  output logic             shift_word_serializer_port_out_bit,
  output logic             shift_word_serializer_port_out_last,
  output logic             shift_word_serializer_port_busy,
  output logic [CNT_W-1:0] shift_word_serializer_port_bit_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

  logic             clk, rst_n, en;
  state_t           state_q, state_d;
  logic [SIZE-1:0]  sreg, sreg_shifted;
  logic [CNT_W-1:0] cnt;
  logic             at_last, in_ready_c, out_valid_c, accept, beat, load, shift;

  assign clk   = shift_word_serializer_port_clk;
  assign rst_n = shift_word_serializer_port_rst;
  assign en    = shift_word_serializer_port_en;

  assign at_last      = (state_q == SHIFT) && (cnt == LAST_IDX);
  assign sreg_shifted = LSB_FIRST ? (sreg >> 1) : (sreg << 1);

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    beat        = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gate keeps in_ready low for the whole reset assertion
        in_ready_c = en & rst_n;
        accept     = shift_word_serializer_port_in_valid & in_ready_c;
        if (accept) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid_c = en;
        in_ready_c  = en & at_last & shift_word_serializer_port_out_ready;
        accept      = shift_word_serializer_port_in_valid & in_ready_c;
        beat        = out_valid_c & shift_word_serializer_port_out_ready;
        if (beat) begin
          if (accept) begin
            load = 1'b1;
          end else begin
            shift = 1'b1;
            if (at_last) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
    end else if (en) begin
      state_q <= state_d;
      if (load) begin
        sreg <= shift_word_serializer_port_in_data;
        cnt  <= '0;
      end else if (shift) begin
        sreg <= sreg_shifted;
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

  assign shift_word_serializer_port_in_ready  = in_ready_c;
  assign shift_word_serializer_port_out_valid = out_valid_c;
  assign shift_word_serializer_port_out_bit   = LSB_FIRST ? sreg[0] : sreg[SIZE-1];
  assign shift_word_serializer_port_out_last  = at_last;
  assign shift_word_serializer_port_busy      = (state_q == SHIFT);
  assign shift_word_serializer_port_bit_cnt   = cnt;

endmodule

// File: tb/tb_shift_word_serializer.sv
// tb/tb_shift_word_serializer.sv - table plus scoreboard bench for shift_word_serializer
module tb_shift_word_serializer;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic       iv[3], orr[3], ir[3], ov[3], ob[3], ol[3], bz[3];
  logic [7:0] din[2];
  logic       din_c;
  logic [3:0] cnt[2];
  logic       cnt_c;

  always #5 clk = ~clk;

  shift_word_serializer #(.SIZE(8), .LSB_FIRST(1'b1)) dut_lsb (
    .shift_word_serializer_port_clk(clk), .shift_word_serializer_port_rst(rst_n),
    .shift_word_serializer_port_en(en), .shift_word_serializer_port_in_valid(iv[0]),
    .shift_word_serializer_port_in_ready(ir[0]), .shift_word_serializer_port_in_data(din[0]),
    .shift_word_serializer_port_out_ready(orr[0]), .shift_word_serializer_port_out_valid(ov[0]),
    .shift_word_serializer_port_out_bit(ob[0]), .shift_word_serializer_port_out_last(ol[0]),
    .shift_word_serializer_port_busy(bz[0]), .shift_word_serializer_port_bit_cnt(cnt[0]));

  shift_word_serializer #(.SIZE(8), .LSB_FIRST(1'b0)) dut_msb (
    .shift_word_serializer_port_clk(clk), .shift_word_serializer_port_rst(rst_n),
    .shift_word_serializer_port_en(en), .shift_word_serializer_port_in_valid(iv[1]),
    .shift_word_serializer_port_in_ready(ir[1]), .shift_word_serializer_port_in_data(din[1]),
    .shift_word_serializer_port_out_ready(orr[1]), .shift_word_serializer_port_out_valid(ov[1]),
    .shift_word_serializer_port_out_bit(ob[1]), .shift_word_serializer_port_out_last(ol[1]),
    .shift_word_serializer_port_busy(bz[1]), .shift_word_serializer_port_bit_cnt(cnt[1]));

  shift_word_serializer #(.SIZE(1), .LSB_FIRST(1'b1)) dut_one (
    .shift_word_serializer_port_clk(clk), .shift_word_serializer_port_rst(rst_n),
    .shift_word_serializer_port_en(en), .shift_word_serializer_port_in_valid(iv[2]),
    .shift_word_serializer_port_in_ready(ir[2]), .shift_word_serializer_port_in_data(din_c),
    .shift_word_serializer_port_out_ready(orr[2]), .shift_word_serializer_port_out_valid(ov[2]),
    .shift_word_serializer_port_out_bit(ob[2]), .shift_word_serializer_port_out_last(ol[2]),
    .shift_word_serializer_port_busy(bz[2]), .shift_word_serializer_port_bit_cnt(cnt_c));

  typedef struct packed {logic b; logic last; logic [3:0] cnt;} beat_t;
  typedef struct {int d; logic [7:0] w; logic [7:0] exp;} vec_t;

  beat_t      sbq[3][$];
  logic [7:0] pend[3];
  logic       s_acc[3], s_beat[3], s_ov[3], s_ir[3], s_last[3], s_bz[3], s_en;
  logic [3:0] s_cnt[3];
  int         n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Snapshot every DUT just before the coming edge; score beats and queue newly accepted words.
  task automatic sample();
    beat_t e;
    int    n;
    s_en = en;
    for (int d = 0; d < 3; d++) begin
      s_ir[d]   = ir[d];
      s_ov[d]   = ov[d];
      s_last[d] = ol[d];
      s_bz[d]   = bz[d];
      s_cnt[d]  = (d == 2) ? {3'b000, cnt_c} : cnt[d];
      s_acc[d]  = iv[d] & ir[d];
      s_beat[d] = ov[d] & orr[d];
      if (s_beat[d]) begin
        if (sbq[d].size() == 0) begin
          check($sformatf("d%0d unexpected_beat", d), 32'd1, 32'd0);
        end else begin
          e = sbq[d].pop_front();
          check($sformatf("d%0d out_bit", d), ob[d], e.b);
          check($sformatf("d%0d out_last", d), ol[d], e.last);
          check($sformatf("d%0d bit_cnt", d), s_cnt[d], e.cnt);
        end
      end
      if (s_acc[d]) begin
        n = (d == 2) ? 1 : 8;
        for (int i = 0; i < n; i++) begin
          e.b = pend[d][i]; e.last = (i == n - 1); e.cnt = 4'(i);
          sbq[d].push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 40 && sbq[d].size() != 0; i++) step();
    check($sformatf("d%0d drain_left", d), sbq[d].size(), 0);
    check($sformatf("d%0d busy_after", d), bz[d], 1'b0);
    check($sformatf("d%0d ovalid_after", d), ov[d], 1'b0);
  endtask

  task automatic send_word(input int d, input logic [7:0] w, input logic [7:0] exp);
    logic got;
    got = 1'b0;
    if (d < 2) din[d] = w; else din_c = w[0];
    pend[d] = exp;
    iv[d]   = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = s_acc[d];
    end
    check($sformatf("d%0d accepted", d), got, 1'b1);
    iv[d] = 1'b0;
    step();
    check($sformatf("d%0d latency_ovalid", d), s_ov[d], 1'b1);
    check($sformatf("d%0d latency_cnt", d), s_cnt[d], 4'd0);
    drain(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int acc, beats, lasts, gap, rdy;
    logic prev_bz, prev_beat;
    logic [3:0] prev_cnt;
    logic got;

    tbl[0] = '{0, 8'hA5, 8'hA5};
    tbl[1] = '{1, 8'hA5, 8'hA5};
    tbl[2] = '{0, 8'h37, 8'h37};
    tbl[3] = '{1, 8'h37, 8'hEC};
    tbl[4] = '{1, 8'h01, 8'h80};
    tbl[5] = '{0, 8'h80, 8'h80};

    rst_n = 1'b0; en = 1'b1; din[0] = '0; din[1] = '0; din_c = 1'b0;
    for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; orr[d] = 1'b1; pend[d] = '0; end
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst d%0d in_ready", d), ir[d], 1'b0);
      check($sformatf("rst d%0d out_valid", d), ov[d], 1'b0);
      check($sformatf("rst d%0d out_last", d), ol[d], 1'b0);
      check($sformatf("rst d%0d busy", d), bz[d], 1'b0);
    end
    check("rst d0 out_bit", ob[0], 1'b0);
    check("rst d0 bit_cnt", cnt[0], 4'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst in_ready", ir[0], 1'b1);
    @(negedge clk);

    foreach (tbl[i]) send_word(tbl[i].d, tbl[i].w, tbl[i].exp);

    // Back-to-back words with in_valid held: no bubble, in_ready only on each last beat.
    acc = 0; beats = 0; lasts = 0; gap = 0; rdy = 0;
    din[0] = 8'h0F; pend[0] = 8'h0F; iv[0] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      step();
      if (s_ir[0] && s_bz[0]) begin
        rdy++;
        check("b2b in_ready_at_cnt", s_cnt[0], 4'd7);
      end
      if (s_beat[0]) begin beats++; if (s_last[0]) lasts++; end
      else if (beats > 0 && beats < 16) gap++;
      if (s_acc[0]) begin
        acc++;
        if (acc == 1) begin din[0] = 8'hF0; pend[0] = 8'hF0; end
        else iv[0] = 1'b0;
      end
    end
    check("b2b accepts", acc, 2);
    check("b2b beats", beats, 16);
    check("b2b lasts", lasts, 2);
    check("b2b gaps", gap, 0);
    check("b2b ready_pulses", rdy, 2);
    drain(0);

    // out_ready 1,0,0 pattern with a 3-cycle enable drop mid-word.
    din[0] = 8'hC3; pend[0] = 8'hC3; iv[0] = 1'b1;
    step();
    check("stall accepted", s_acc[0], 1'b1);
    iv[0] = 1'b0; prev_bz = 1'b0; prev_beat = 1'b0; prev_cnt = '0;
    for (int c = 0; c < 30; c++) begin
      orr[0] = (c % 3 == 0);
      en = !(c >= 4 && c <= 6);
      step();
      if (!s_en) check("stall ovalid_en0", s_ov[0], 1'b0);
      if (prev_bz && !prev_beat && s_bz[0]) check("stall cnt_frozen", s_cnt[0], prev_cnt);
      prev_bz = s_bz[0]; prev_beat = s_beat[0]; prev_cnt = s_cnt[0];
    end
    en = 1'b1; orr[0] = 1'b1;
    drain(0);

    // Asynchronous reset at bit_cnt=3 abandons the word.
    din[0] = 8'h6B; pend[0] = 8'h6B; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = s_beat[0] && (s_cnt[0] == 4'd2);
    end
    check("rst_mid reached_cnt3", cnt[0], 4'd3);
    check("rst_mid out_bit_before", ob[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid in_ready", ir[0], 1'b0);
    check("rst_mid out_valid", ov[0], 1'b0);
    check("rst_mid out_bit", ob[0], 1'b0);
    check("rst_mid out_last", ol[0], 1'b0);
    check("rst_mid busy", bz[0], 1'b0);
    check("rst_mid bit_cnt", cnt[0], 4'd0);
    sbq[0].delete();
    @(negedge clk);
    check("rst_hold in_ready", ir[0], 1'b0);
    check("rst_hold out_valid", ov[0], 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_release in_ready", ir[0], 1'b1);
    @(negedge clk);
    send_word(0, 8'h6B, 8'h6B);

    // SIZE=1: consecutive words, each a single last beat, no idle cycle.
    din_c = 1'b1; pend[2] = 8'h01; iv[2] = 1'b1;
    step();
    check("one acc1", s_acc[2], 1'b1);
    din_c = 1'b0; pend[2] = 8'h00;
    step();
    check("one acc2", s_acc[2], 1'b1);
    check("one beat1", s_beat[2], 1'b1);
    check("one last1", s_last[2], 1'b1);
    iv[2] = 1'b0;
    step();
    check("one beat2", s_beat[2], 1'b1);
    check("one last2", s_last[2], 1'b1);
    check("one ready2", s_ir[2], 1'b1);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
